// File: rtl/iterative_shift_sequencer.sv
// Variable-amount shifter folded in time: one power-of-two stage per clock,
// with valid/ready handshakes on both the request and the result side.
module iterative_shift_sequencer #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [N-1:0]         up_data,
  input  logic [$clog2(N)-1:0] up_amt,
  input  logic                 up_dir,
  input  logic                 up_arith,
  output logic                 down_valid,
  input  logic                 down_ready,
  output logic [N-1:0]         down_data,
  output logic                 busy
);

  localparam int L = $clog2(N);
  localparam logic [L-1:0] K_LAST = L'(L - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic         r_busy;
  logic [L-1:0] r_k;
  logic [L-1:0] r_amt;
  logic         r_dir;
  logic         r_fill;
  logic [N-1:0] r_work;
  logic [N-1:0] w_stage [L];
  logic [N-1:0] w_work_shifted;

  // Candidate result of every stage; only the one matching r_k is used.
  // r_fill already folds in direction and arithmetic mode, so left shifts never see it.
  for (genvar gi = 0; gi < L; gi++) begin : g_stage
    localparam int S = 1 << gi;
    assign w_stage[gi] = r_dir ? {{S{r_fill}}, r_work[N-1:S]}
                               : {r_work[N-1-S:0], {S{1'b0}}};
  end

  always_comb begin
    w_work_shifted = r_work;
    for (int i = 0; i < L; i++) begin
      if ((r_k == L'(i)) && r_amt[i]) begin
        w_work_shifted = w_stage[i];
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (up_valid)        w_state_next = S_SHIFT;
      S_SHIFT: if (r_k == K_LAST)   w_state_next = S_DONE;
      S_DONE:  if (down_ready)      w_state_next = S_IDLE;
      default:                      w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next != S_IDLE);
    end
  end

  // The sign fill is frozen at accept so later stages never re-derive it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k    <= '0;
      r_amt  <= '0;
      r_dir  <= 1'b0;
      r_fill <= 1'b0;
      r_work <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (up_valid) begin
            r_work <= up_data;
            r_amt  <= up_amt;
            r_dir  <= up_dir;
            r_fill <= up_dir & up_arith & up_data[N-1];
            r_k    <= '0;
          end
        end
        S_SHIFT: begin
          r_work <= w_work_shifted;
          r_k    <= r_k + L'(1);
        end
        default: ;
      endcase
    end
  end

  assign up_ready   = (r_state == S_IDLE) && !rst;
  assign down_valid = (r_state == S_DONE);
  assign down_data  = r_work;
  assign busy       = r_busy;

endmodule
